// File: rtl/image_read_sequencer_pkg.sv
// Shared defaults, tag width and FSM encoding for the image read sequencer.
package image_mem_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam int IMG_W_DEF  = 64;
  localparam int IMG_H_DEF  = 64;
  localparam int TAG_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  // Two spare slots beyond the read latency keep issue running at full rate.
  function automatic int fifo_depth(input int rd_lat);
    return rd_lat + 2;
  endfunction

endpackage

// File: rtl/image_read_sequencer_if.sv
// BRAM read port plus tagged pixel stream shared by the sequencer and its neighbours.
interface image_read_sequencer_if
  import image_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dout;
  logic [DATA_W-1:0] pix_data;
  logic [TAG_W-1:0]  pix_row;
  logic [TAG_W-1:0]  pix_col;
  logic              pix_last;
  logic              pix_valid;
  logic              pix_ready;

  modport master (
    output mem_en, mem_addr, pix_data, pix_row, pix_col, pix_last, pix_valid,
    input  mem_dout, pix_ready
  );

  modport slave (
    input  mem_en, mem_addr, pix_data, pix_row, pix_col, pix_last, pix_valid,
    output mem_dout, pix_ready
  );

endinterface

// File: rtl/image_read_sequencer_fifo.sv
// Small synchronous FIFO that soaks up returning BRAM words while the pixel consumer stalls.
module pix_skid_fifo
  import image_mem_pkg::*;
#(
  parameter int  DEPTH  = 3,
  parameter int  DATA_W = DATA_W_DEF,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int PTR_W  = $clog2(DEPTH)
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] store [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              wr_en;
  logic              rd_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    else return p + PTR_W'(1);
  endfunction

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign head  = store[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
    end else begin
      if (wr_en) begin
        store[wr_ptr] <= push_data;
        wr_ptr        <= ptr_inc(wr_ptr);
      end
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  pix_skid_fifo_chk u_chk (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (rd_en),
    .full (full)
  );

endmodule

// Overflow watchdog: the issue credit must never let a word arrive at a full FIFO.
module pix_skid_fifo_chk (
  input logic clk,
  input logic rst,
  input logic push,
  input logic pop,
  input logic full
);

  no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: rtl/image_read_sequencer.sv
// Raster-order BRAM reader: credit-limited issue, latency tracking and a tagged pixel stream.
module image_read_sequencer
  import image_mem_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                DATA_W    = DATA_W_DEF,
  parameter int                IMG_W     = IMG_W_DEF,
  parameter int                IMG_H     = IMG_H_DEF,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                RD_LAT    = 1
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  image_read_sequencer_if.master bus
);

  localparam int               FIFO_DEPTH = fifo_depth(RD_LAT);
  localparam int               CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0]      TOTAL      = 32'(IMG_W * IMG_H);
  localparam logic [TAG_W-1:0] LAST_COL   = TAG_W'(IMG_W - 1);
  localparam logic [TAG_W-1:0] LAST_ROW   = TAG_W'(IMG_H - 1);

  seq_state_t        state;
  seq_state_t        state_next;
  logic [31:0]       issued;
  logic [ADDR_W-1:0] addr;
  logic [RD_LAT-1:0] inflight_sr;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic [TAG_W-1:0]  row;
  logic [TAG_W-1:0]  col;
  logic              accept;
  logic              credit_ok;
  logic              issue;
  logic              push;
  logic              xfer;
  logic              last_pix;

  // Words already requested count against FIFO space so a stalled consumer can never overflow it.
  assign accept    = (state == ST_IDLE) && start;
  assign credit_ok = !fifo_full &&
                     (({1'b0, fifo_count} + {1'b0, inflight}) < (CNT_W + 1)'(FIFO_DEPTH));
  assign issue     = (state == ST_READ) && (issued < TOTAL) && credit_ok;
  assign push      = inflight_sr[RD_LAT-1];
  assign xfer      = !fifo_empty && bus.pix_ready;
  assign last_pix  = (row == LAST_ROW) && (col == LAST_COL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_READ;
        else       state_next = ST_IDLE;
      end
      ST_READ: begin
        if (issue && (issued == TOTAL - 32'd1)) state_next = ST_DRAIN;
        else                                    state_next = ST_READ;
      end
      ST_DRAIN: begin
        if (xfer && last_pix) state_next = ST_DONE;
        else                  state_next = ST_DRAIN;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued <= '0;
      addr   <= '0;
    end else if (accept) begin
      issued <= '0;
      addr   <= BASE_ADDR;
    end else if (issue) begin
      issued <= issued + 32'd1;
      addr   <= addr + ADDR_W'(1);
    end
  end

  // Valid bit rides alongside each read; the word is captured as its bit falls off the end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_sr <= '0;
      inflight    <= '0;
    end else begin
      inflight_sr[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) inflight_sr[i] <= inflight_sr[i-1];
      case ({issue, push})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      row <= '0;
      col <= '0;
    end else if (xfer) begin
      if (col == LAST_COL) begin
        col <= '0;
        row <= last_pix ? '0 : row + TAG_W'(1);
      end else begin
        col <= col + TAG_W'(1);
      end
    end
  end

  pix_skid_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bus.mem_dout),
    .pop       (xfer),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign busy          = (state == ST_READ) || (state == ST_DRAIN);
  assign done          = (state == ST_DONE);
  assign bus.mem_en    = issue;
  assign bus.mem_addr  = addr;
  assign bus.pix_valid = !fifo_empty;
  assign bus.pix_data  = fifo_head;
  assign bus.pix_row   = row;
  assign bus.pix_col   = col;
  assign bus.pix_last  = !fifo_empty && last_pix;

endmodule

// File: tb/tb_image_read_sequencer.sv
// Directed bench: three sequencer instances (4x2 lat1, 4x2 lat3, 1x1 at 0xFFFF) with BRAM models.
module tb_image_read_sequencer;
  import image_mem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic start_a, start_b, start_c;
  logic busy_a, busy_b, busy_c;
  logic done_a, done_b, done_c;
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  image_read_sequencer_if #(.ADDR_W(16), .DATA_W(16)) if_a ();
  image_read_sequencer_if #(.ADDR_W(16), .DATA_W(16)) if_b ();
  image_read_sequencer_if #(.ADDR_W(16), .DATA_W(16)) if_c ();

  image_read_sequencer #(.ADDR_W(16), .DATA_W(16), .IMG_W(4), .IMG_H(2),
                         .BASE_ADDR(16'h0000), .RD_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a), .bus(if_a));
  image_read_sequencer #(.ADDR_W(16), .DATA_W(16), .IMG_W(4), .IMG_H(2),
                         .BASE_ADDR(16'h0000), .RD_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .bus(if_b));
  image_read_sequencer #(.ADDR_W(16), .DATA_W(16), .IMG_W(1), .IMG_H(1),
                         .BASE_ADDR(16'hFFFF), .RD_LAT(1)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .busy(busy_c), .done(done_c), .bus(if_c));

  // BRAM models: mem[a] = 0x0100 + a, output registered RD_LAT times.
  logic [15:0] b_p0, b_p1;
  always @(posedge clk) begin
    if_a.mem_dout <= if_a.mem_en ? 16'h0100 + if_a.mem_addr : 16'hDEAD;
    if_c.mem_dout <= if_c.mem_en ? 16'h0100 + if_c.mem_addr : 16'hDEAD;
    b_p0          <= if_b.mem_en ? 16'h0100 + if_b.mem_addr : 16'hDEAD;
    b_p1          <= b_p0;
    if_b.mem_dout <= b_p1;
  end

  // Capture transfers (stamped with the edge that completes them) and issued addresses.
  logic [48:0] pa_q[$], pb_q[$], pc_q[$];
  int          pa_e[$];
  logic [15:0] aa_q[$], ac_q[$];
  int          aa_e[$];
  always @(negedge clk) begin
    if (if_a.pix_valid && if_a.pix_ready) begin
      pa_q.push_back({if_a.pix_last, if_a.pix_row, if_a.pix_col, if_a.pix_data});
      pa_e.push_back(cyc + 1);
    end
    if (if_b.pix_valid && if_b.pix_ready)
      pb_q.push_back({if_b.pix_last, if_b.pix_row, if_b.pix_col, if_b.pix_data});
    if (if_c.pix_valid && if_c.pix_ready)
      pc_q.push_back({if_c.pix_last, if_c.pix_row, if_c.pix_col, if_c.pix_data});
    if (if_a.mem_en) begin
      aa_q.push_back(if_a.mem_addr);
      aa_e.push_back(cyc);
    end
    if (if_c.mem_en) ac_q.push_back(if_c.mem_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_a();
    pa_q.delete(); pa_e.delete(); aa_q.delete(); aa_e.delete();
  endtask

  task automatic test_reset();
    tick(); tick();
    n_total++;
    if ({busy_a, done_a, if_a.mem_en, if_a.pix_valid, if_a.pix_last} !== 5'b0)
      $display("FAIL reset_ctrl_a: got %b want 00000",
               {busy_a, done_a, if_a.mem_en, if_a.pix_valid, if_a.pix_last});
    else n_pass++;
    n_total++;
    if ({if_a.mem_addr, if_a.pix_data, if_a.pix_row, if_a.pix_col} !== 64'd0)
      $display("FAIL reset_data_a: got %h want 0",
               {if_a.mem_addr, if_a.pix_data, if_a.pix_row, if_a.pix_col});
    else n_pass++;
    n_total++;
    if ({busy_c, done_c, if_c.pix_valid, if_c.pix_last, busy_b, if_b.pix_valid} !== 6'b0)
      $display("FAIL reset_ctrl_bc: got %b want 000000",
               {busy_c, done_c, if_c.pix_valid, if_c.pix_last, busy_b, if_b.pix_valid});
    else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_frame();
    int n;
    int done_e;
    logic [48:0] exp_px;
    clear_a();
    if_a.pix_ready = 1'b1;
    start_a = 1'b1; tick(); start_a = 1'b0;
    n_total++;
    if ({busy_a, if_a.mem_en, if_a.mem_addr} !== {1'b1, 1'b1, 16'h0000})
      $display("FAIL frame_issue0: got %b/%b/%h want 1/1/0000", busy_a, if_a.mem_en, if_a.mem_addr);
    else n_pass++;
    n = 0;
    while (if_a.pix_valid !== 1'b1 && n < 20) begin tick(); n++; end
    n_total++;
    if (n !== 2) $display("FAIL frame_first_valid: got %0d edges want 2", n); else n_pass++;
    n = 0;
    while (done_a !== 1'b1 && n < 100) begin tick(); n++; end
    done_e = cyc;
    n_total++;
    if ({done_a, busy_a} !== 2'b10) $display("FAIL frame_done: got %b want 10", {done_a, busy_a});
    else n_pass++;
    n_total++;
    if (pa_q.size() !== 8) $display("FAIL frame_count: got %0d want 8", pa_q.size()); else n_pass++;
    for (int i = 0; i < pa_q.size() && i < 8; i++) begin
      exp_px = {(i == 7), 16'(i / 4), 16'(i % 4), 16'(32'h0100 + i)};
      n_total++;
      if (pa_q[i] !== exp_px) $display("FAIL frame_px%0d: got %h want %h", i, pa_q[i], exp_px);
      else n_pass++;
    end
    n_total++;
    if (pa_e.size() < 8 || pa_e[7] !== done_e)
      $display("FAIL frame_done_timing: final xfer edge %0d, done edge %0d", pa_e.size() < 8 ? -1 : pa_e[7], done_e);
    else n_pass++;
    n_total++;
    if (aa_q.size() !== 8) $display("FAIL frame_addr_count: got %0d want 8", aa_q.size()); else n_pass++;
    for (int i = 0; i < aa_q.size() && i < 8; i++) begin
      n_total++;
      if (aa_q[i] !== 16'(i) || aa_e[i] !== aa_e[0] + i)
        $display("FAIL frame_addr%0d: got %h@%0d want %h@%0d", i, aa_q[i], aa_e[i], 16'(i), aa_e[0] + i);
      else n_pass++;
    end
    tick();
    n_total++;
    if ({done_a, busy_a, if_a.mem_addr} !== {2'b00, 16'h0008})
      $display("FAIL frame_after_done: got %b/%h want 00/0008", {done_a, busy_a}, if_a.mem_addr);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int n;
    logic [48:0] exp_px;
    clear_a();
    if_a.pix_ready = 1'b0;
    start_a = 1'b1; tick(); start_a = 1'b0;
    n = 0;
    while (if_a.pix_valid !== 1'b1 && n < 20) begin tick(); n++; end
    for (int i = 0; i < 6; i++) begin
      n_total++;
      if ({if_a.pix_valid, if_a.pix_data} !== {1'b1, 16'h0100})
        $display("FAIL bp_hold%0d: got %b/%h want 1/0100", i, if_a.pix_valid, if_a.pix_data);
      else n_pass++;
      tick();
    end
    n_total++;
    if ({if_a.mem_en, 8'(aa_q.size())} !== {1'b0, 8'd3})
      $display("FAIL bp_credit: mem_en %b issued %0d want 0/3", if_a.mem_en, aa_q.size());
    else n_pass++;
    if_a.pix_ready = 1'b1;
    n = 0;
    while (done_a !== 1'b1 && n < 100) begin tick(); n++; end
    n_total++;
    if (pa_q.size() !== 8 || aa_q.size() !== 8)
      $display("FAIL bp_count: got %0d px %0d rd want 8/8", pa_q.size(), aa_q.size());
    else n_pass++;
    for (int i = 0; i < pa_q.size() && i < 8; i++) begin
      exp_px = {(i == 7), 16'(i / 4), 16'(i % 4), 16'(32'h0100 + i)};
      n_total++;
      if (pa_q[i] !== exp_px || aa_q[i] !== 16'(i))
        $display("FAIL bp_px%0d: got %h/%h want %h/%h", i, pa_q[i], aa_q[i], exp_px, 16'(i));
      else n_pass++;
    end
    tick();
  endtask

  task automatic test_toggle_lat3();
    int n;
    int first_n;
    logic [48:0] exp_px;
    pb_q.delete();
    if_b.pix_ready = 1'b0;
    start_b = 1'b1; tick(); start_b = 1'b0;
    n = 0;
    first_n = -1;
    while (done_b !== 1'b1 && n < 200) begin
      if (first_n < 0 && if_b.pix_valid === 1'b1) first_n = n;
      if_b.pix_ready = ~if_b.pix_ready;
      tick();
      n++;
    end
    n_total++;
    if (first_n !== 4) $display("FAIL lat3_first_valid: got %0d edges want 4", first_n); else n_pass++;
    n_total++;
    if ({done_b, 8'(pb_q.size())} !== {1'b1, 8'd8})
      $display("FAIL lat3_done_count: done %b px %0d want 1/8", done_b, pb_q.size());
    else n_pass++;
    for (int i = 0; i < pb_q.size() && i < 8; i++) begin
      exp_px = {(i == 7), 16'(i / 4), 16'(i % 4), 16'(32'h0100 + i)};
      n_total++;
      if (pb_q[i] !== exp_px) $display("FAIL lat3_px%0d: got %h want %h", i, pb_q[i], exp_px);
      else n_pass++;
    end
    if_b.pix_ready = 1'b0;
    tick();
  endtask

  task automatic test_restart();
    int n;
    logic [48:0] exp_px;
    clear_a();
    if_a.pix_ready = 1'b1;
    start_a = 1'b1; tick(); start_a = 1'b0;
    tick(); tick(); tick();
    start_a = 1'b1; tick(); start_a = 1'b0;
    n_total++;
    if (busy_a !== 1'b1) $display("FAIL restart_mid_busy: got %b want 1", busy_a); else n_pass++;
    n = 0;
    while (done_a !== 1'b1 && n < 100) begin tick(); n++; end
    start_a = 1'b1; tick(); start_a = 1'b0;
    n_total++;
    if ({busy_a, if_a.mem_en} !== 2'b00)
      $display("FAIL restart_in_done: got %b want 00", {busy_a, if_a.mem_en});
    else n_pass++;
    n_total++;
    if (aa_q.size() !== 8 || pa_q.size() !== 8)
      $display("FAIL restart_mid_count: got %0d rd %0d px want 8/8", aa_q.size(), pa_q.size());
    else n_pass++;
    for (int i = 0; i < aa_q.size() && i < 8; i++) begin
      n_total++;
      if (aa_q[i] !== 16'(i)) $display("FAIL restart_mid_addr%0d: got %h want %h", i, aa_q[i], 16'(i));
      else n_pass++;
    end
    clear_a();
    start_a = 1'b1; tick(); start_a = 1'b0;
    n = 0;
    while (done_a !== 1'b1 && n < 100) begin tick(); n++; end
    n_total++;
    if (pa_q.size() !== 8 || aa_q.size() !== 8)
      $display("FAIL restart_second_count: got %0d px %0d rd want 8/8", pa_q.size(), aa_q.size());
    else n_pass++;
    for (int i = 0; i < pa_q.size() && i < 8; i++) begin
      exp_px = {(i == 7), 16'(i / 4), 16'(i % 4), 16'(32'h0100 + i)};
      n_total++;
      if (pa_q[i] !== exp_px || aa_q[i] !== 16'(i))
        $display("FAIL restart_second_px%0d: got %h/%h want %h/%h", i, pa_q[i], aa_q[i], exp_px, 16'(i));
      else n_pass++;
    end
    tick();
  endtask

  task automatic test_async_reset();
    int n;
    logic saw_valid;
    logic [48:0] exp_px;
    clear_a();
    if_a.pix_ready = 1'b1;
    start_a = 1'b1; tick(); start_a = 1'b0;
    n = 0;
    while (pa_q.size() < 3 && n < 50) begin tick(); n++; end
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({busy_a, done_a, if_a.mem_en, if_a.pix_valid, if_a.pix_last} !== 5'b0)
      $display("FAIL arst_ctrl: got %b want 00000",
               {busy_a, done_a, if_a.mem_en, if_a.pix_valid, if_a.pix_last});
    else n_pass++;
    n_total++;
    if ({if_a.mem_addr, if_a.pix_data, if_a.pix_row, if_a.pix_col} !== 64'd0)
      $display("FAIL arst_data: got %h want 0",
               {if_a.mem_addr, if_a.pix_data, if_a.pix_row, if_a.pix_col});
    else n_pass++;
    tick(); tick();
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      saw_valid = saw_valid | if_a.pix_valid | busy_a;
      tick();
    end
    n_total++;
    if (saw_valid !== 1'b0) $display("FAIL arst_stale: got %b want 0", saw_valid); else n_pass++;
    clear_a();
    start_a = 1'b1; tick(); start_a = 1'b0;
    n = 0;
    while (done_a !== 1'b1 && n < 100) begin tick(); n++; end
    n_total++;
    if (pa_q.size() !== 8 || aa_q.size() !== 8)
      $display("FAIL arst_restart_count: got %0d px %0d rd want 8/8", pa_q.size(), aa_q.size());
    else n_pass++;
    for (int i = 0; i < pa_q.size() && i < 8; i++) begin
      exp_px = {(i == 7), 16'(i / 4), 16'(i % 4), 16'(32'h0100 + i)};
      n_total++;
      if (pa_q[i] !== exp_px || aa_q[i] !== 16'(i))
        $display("FAIL arst_px%0d: got %h/%h want %h/%h", i, pa_q[i], aa_q[i], exp_px, 16'(i));
      else n_pass++;
    end
    tick();
  endtask

  task automatic test_single_pixel();
    int n;
    pc_q.delete(); ac_q.delete();
    if_c.pix_ready = 1'b1;
    start_c = 1'b1; tick(); start_c = 1'b0;
    n_total++;
    if ({if_c.mem_en, if_c.mem_addr} !== {1'b1, 16'hFFFF})
      $display("FAIL single_issue: got %b/%h want 1/FFFF", if_c.mem_en, if_c.mem_addr);
    else n_pass++;
    tick();
    n_total++;
    if ({if_c.mem_en, if_c.mem_addr} !== {1'b0, 16'h0000})
      $display("FAIL single_addr_wrap: got %b/%h want 0/0000", if_c.mem_en, if_c.mem_addr);
    else n_pass++;
    n = 0;
    while (done_c !== 1'b1 && n < 50) begin tick(); n++; end
    n_total++;
    if ({done_c, busy_c} !== 2'b10) $display("FAIL single_done: got %b want 10", {done_c, busy_c});
    else n_pass++;
    n_total++;
    if (ac_q.size() !== 1 || pc_q.size() !== 1)
      $display("FAIL single_count: got %0d rd %0d px want 1/1", ac_q.size(), pc_q.size());
    else if (ac_q[0] !== 16'hFFFF || pc_q[0] !== {1'b1, 16'h0000, 16'h0000, 16'h00FF})
      $display("FAIL single_px: got %h/%h want FFFF/%h", ac_q[0], pc_q[0],
               {1'b1, 16'h0000, 16'h0000, 16'h00FF});
    else n_pass++;
    tick();
    n_total++;
    if ({done_c, busy_c} !== 2'b00) $display("FAIL single_done_pulse: got %b want 00", {done_c, busy_c});
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    if_a.pix_ready = 1'b0; if_b.pix_ready = 1'b0; if_c.pix_ready = 1'b0;
    test_reset();
    test_frame();
    test_backpressure();
    test_toggle_lat3();
    test_restart();
    test_async_reset();
    test_single_pixel();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
